// File: rtl/reg_writeback_queue_if.sv
// ---------------------------------------------------------------------------
// reg_writeback_queue_if
//   Bundles every non-clock/reset signal of the register write-back queue.
//   master : the queue itself (accepts execute results, drives the register
//            file write port, answers forwarding lookups, reports status).
//   slave  : the surroundings (execute stage, register file, operand fetch).
//
//   Execute side : in_valid, in_addr, in_data -> queue ; in_ready <- queue
//   Regfile side : rf_wr_en, rf_wr_addr, rf_wr_data <- queue ;
//                  rf_wr_success -> queue
//   Forwarding   : fwd_addr1/2 -> queue ; fwd_hit1/2, fwd_data1/2 <- queue
//   Status       : pending, empty, err_timeout <- queue
// ---------------------------------------------------------------------------
interface reg_writeback_queue_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              rf_wr_success;

  logic [ADDR_W-1:0] fwd_addr1;
  logic [ADDR_W-1:0] fwd_addr2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  logic [CNT_W-1:0]  pending;
  logic              empty;
  logic              err_timeout;

  modport master (
    input  in_valid, in_addr, in_data, rf_wr_success, fwd_addr1, fwd_addr2,
    output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
           pending, empty, err_timeout
  );

  modport slave (
    output in_valid, in_addr, in_data, rf_wr_success, fwd_addr1, fwd_addr2,
    input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
           pending, empty, err_timeout
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// ---------------------------------------------------------------------------
// reg_writeback_queue
//   Small FIFO between the execute stage and the 8 x 8-bit register file.
//   Results are queued on in_valid & in_ready and committed one at a time
//   over the rf_wr_en / rf_wr_success handshake.  Two combinational
//   forwarding ports let operand fetch see values that are still queued.
//
// Ports
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : reg_writeback_queue_if.master (execute, regfile, forwarding,
//            status signals)
//
// Parameters
//   DATA_W (8), ADDR_W (3), DEPTH (4, power of two >= 2),
//   TIMEOUT (15, 1..255 WRITE cycles without success before a retry)
//
// Build option
//   WB_COALESCE_EN : when defined, a push to an address already queued in a
//   non-head slot overwrites that slot's data instead of taking a new slot.
// ---------------------------------------------------------------------------
module reg_writeback_queue #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst_n,
  reg_writeback_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = 8;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  state_t            state_reg, state_next;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic              err_reg, err_next;

  logic              full;
  logic              pop;
  logic              push;
  logic              push_new;
  logic              coalesce_hit;
  logic [PTR_W-1:0]  coalesce_idx;
  logic              in_ready_int;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Slots viewed by age: index 0 is the head (oldest), higher is younger.
  logic [PTR_W-1:0]  age_idx  [DEPTH];
  logic              age_occ  [DEPTH];
  logic [ADDR_W-1:0] age_addr [DEPTH];
  logic [DATA_W-1:0] age_data [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_idx[gi]  = head_reg + PTR_W'(gi);
      assign age_occ[gi]  = CNT_W'(gi) < count_reg;
      assign age_addr[gi] = addr_mem[age_idx[gi]];
      assign age_data[gi] = data_mem[age_idx[gi]];
    end
  endgenerate

  assign full = (count_reg == CNT_W'(DEPTH));

  // Scan oldest to youngest so the last match (the youngest) wins.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    r = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_occ[k] && (age_addr[k] == a)) begin
        r = {1'b1, age_data[k]};
      end
    end
    return r;
  endfunction

  assign {bus.fwd_hit1, bus.fwd_data1} = fwd_lookup(bus.fwd_addr1);
  assign {bus.fwd_hit2, bus.fwd_data2} = fwd_lookup(bus.fwd_addr2);

`ifdef WB_COALESCE_EN
  // Search non-head slots only: the head may be on the write port already.
  always_comb begin
    coalesce_hit = 1'b0;
    coalesce_idx = head_reg;
    for (int k = 1; k < DEPTH; k++) begin
      if (age_occ[k] && (age_addr[k] == bus.in_addr)) begin
        coalesce_hit = 1'b1;
        coalesce_idx = age_idx[k];
      end
    end
  end
  assign in_ready_int = !full || coalesce_hit;
`else
  assign coalesce_hit = 1'b0;
  assign coalesce_idx = head_reg;
  assign in_ready_int = !full;
`endif

  assign push     = bus.in_valid && in_ready_int;
  assign push_new = push && !coalesce_hit;

  // Write-port FSM: IDLE -> WRITE (until success or timeout) -> GAP -> ...
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    err_next   = err_reg;
    pop        = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) state_next = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_addr = age_addr[0];
        wr_data = age_data[0];
        if (bus.rf_wr_success) begin
          pop        = 1'b1;
          timer_next = '0;
          state_next = GAP;
        end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
          // TIMEOUT-th WRITE cycle without success: retry the same head.
          err_next   = 1'b1;
          timer_next = '0;
          state_next = GAP;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      GAP: begin
        state_next = (count_reg != '0) ? WRITE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      err_reg   <= 1'b0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      err_reg   <= err_next;
      if (pop)      head_reg <= head_reg + 1'b1;
      if (push_new) tail_reg <= tail_reg + 1'b1;
      case ({push_new, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        addr_mem[k] <= '0;
        data_mem[k] <= '0;
      end
    end else if (push_new) begin
      addr_mem[tail_reg] <= bus.in_addr;
      data_mem[tail_reg] <= bus.in_data;
    end else if (push) begin
      data_mem[coalesce_idx] <= bus.in_data;
    end
  end

  assign bus.in_ready    = in_ready_int;
  assign bus.rf_wr_en    = wr_en;
  assign bus.rf_wr_addr  = wr_addr;
  assign bus.rf_wr_data  = wr_data;
  assign bus.pending     = count_reg;
  assign bus.empty       = (count_reg == '0);
  assign bus.err_timeout = err_reg;

endmodule
